// File: rtl/cc_resp_scheduler_if.sv
// Bundle of the tag-push, source and downstream R-channel control signals
// of the response scheduler. slave = scheduler side, master = driver side.
interface cc_resp_scheduler_if #(
    parameter int DEPTH = 4
);
    localparam int OW = $clog2(DEPTH) + 1;

    logic          tag_wren_i;
    logic          tag_hit_i;
    logic          tag_afull_o;
    logic          tag_full_o;
    logic [OW-1:0] occupancy_o;
    logic          mem_rvalid_i;
    logic          mem_rlast_i;
    logic          mem_rready_o;
    logic          ser_rvalid_i;
    logic          ser_rlast_i;
    logic          ser_rready_o;
    logic          inct_rvalid_o;
    logic          inct_rready_i;
    logic          inct_rlast_o;
    logic          inct_sel_o;
    logic          err_o;

    modport slave (
        input  tag_wren_i, tag_hit_i,
        input  mem_rvalid_i, mem_rlast_i,
        input  ser_rvalid_i, ser_rlast_i,
        input  inct_rready_i,
        output tag_afull_o, tag_full_o, occupancy_o,
        output mem_rready_o, ser_rready_o,
        output inct_rvalid_o, inct_rlast_o, inct_sel_o,
        output err_o
    );

    modport master (
        output tag_wren_i, tag_hit_i,
        output mem_rvalid_i, mem_rlast_i,
        output ser_rvalid_i, ser_rlast_i,
        output inct_rready_i,
        input  tag_afull_o, tag_full_o, occupancy_o,
        input  mem_rready_o, ser_rready_o,
        input  inct_rvalid_o, inct_rlast_o, inct_sel_o,
        input  err_o
    );
endinterface

// File: rtl/cc_resp_scheduler.sv
// Response scheduler: a FIFO of hit/miss order tags steers fixed-length
// bursts from either the serializer (hit) or memory (miss) onto the
// downstream R channel. Handshake is a zero-latency pass-through; the
// burst length is counted locally and source rlast is only checked.
module cc_resp_scheduler #(
    parameter int DEPTH           = 4,
    parameter int BURST_LEN       = 8,
    parameter int AFULL_THRESHOLD = 2
) (
    input logic                clk,
    input logic                rst_n,
    cc_resp_scheduler_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int OW = AW + 1;
    localparam int CW = $clog2(BURST_LEN);
    localparam logic [CW-1:0] LAST_CNT = CW'(BURST_LEN - 1);
    localparam logic [OW-1:0] FULL_OCC = OW'(DEPTH);
    localparam logic [OW-1:0] AFULL_OCC = OW'(AFULL_THRESHOLD);

    typedef enum logic [1:0] {S_IDLE, S_HIT, S_MISS} state_t;

    state_t          r_state, w_next_state;
    logic [CW-1:0]   r_cnt, w_next_cnt;
    logic [DEPTH-1:0] r_tags;
    logic [AW-1:0]   r_wptr, r_rptr;
    logic [OW-1:0]   r_count;
    logic            r_err;

    logic w_empty, w_full, w_push, w_drop, w_pop, w_head;
    logic w_sel, w_rvalid, w_rlast, w_mrdy, w_srdy, w_src_last;
    logic w_is_last, w_beat, w_last_err;

    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == FULL_OCC);
    // A push into a full queue is dropped even if a pop frees a slot this cycle.
    assign w_push    = bus.tag_wren_i && !w_full;
    assign w_drop    = bus.tag_wren_i && w_full;
    assign w_head    = r_tags[r_rptr];
    assign w_is_last = (r_cnt == LAST_CNT);

    // State register and beat counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
        end
    end

    // Source steering, beat counting and tag pop / burst chaining.
    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        w_pop        = 1'b0;
        w_sel        = 1'b0;
        w_rvalid     = 1'b0;
        w_rlast      = 1'b0;
        w_mrdy       = 1'b0;
        w_srdy       = 1'b0;
        w_src_last   = 1'b0;
        case (r_state)
            S_HIT: begin
                w_sel      = 1'b1;
                w_rvalid   = bus.ser_rvalid_i;
                w_srdy     = bus.inct_rready_i;
                w_src_last = bus.ser_rlast_i;
                w_rlast    = w_is_last;
            end
            S_MISS: begin
                w_rvalid   = bus.mem_rvalid_i;
                w_mrdy     = bus.inct_rready_i;
                w_src_last = bus.mem_rlast_i;
                w_rlast    = w_is_last;
            end
            default: begin
                if (!w_empty) begin
                    w_pop        = 1'b1;
                    w_next_state = w_head ? S_HIT : S_MISS;
                    w_next_cnt   = '0;
                end
            end
        endcase
        w_beat     = w_rvalid && bus.inct_rready_i;
        w_last_err = w_beat && (w_src_last != w_is_last);
        if (w_beat) begin
            if (w_is_last) begin
                w_next_cnt = '0;
                if (!w_empty) begin
                    w_pop        = 1'b1;
                    w_next_state = w_head ? S_HIT : S_MISS;
                end else begin
                    w_next_state = S_IDLE;
                end
            end else begin
                w_next_cnt = r_cnt + CW'(1);
            end
        end
    end

    // Tag FIFO storage/pointers and the sticky protocol-error flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_tags  <= '0;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_err   <= 1'b0;
        end else begin
            if (w_push) begin
                r_tags[r_wptr] <= bus.tag_hit_i;
                r_wptr         <= r_wptr + AW'(1);
            end
            if (w_pop) r_rptr <= r_rptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + OW'(1);
                2'b01:   r_count <= r_count - OW'(1);
                default: r_count <= r_count;
            endcase
            if (w_drop || w_last_err) r_err <= 1'b1;
        end
    end

    assign bus.tag_full_o    = w_full;
    assign bus.tag_afull_o   = (r_count >= AFULL_OCC);
    assign bus.occupancy_o   = r_count;
    assign bus.mem_rready_o  = w_mrdy;
    assign bus.ser_rready_o  = w_srdy;
    assign bus.inct_rvalid_o = w_rvalid;
    assign bus.inct_rlast_o  = w_rlast;
    assign bus.inct_sel_o    = w_sel;
    assign bus.err_o         = r_err;
endmodule

// File: tb/tb_cc_resp_scheduler.sv
// Bench for cc_resp_scheduler: directed scenarios plus a randomized run,
// every cycle compared against a transaction-level model (tag queue plus
// "current burst" record).
module tb_cc_resp_scheduler;
    localparam int DEPTH = 4;
    localparam int BL    = 8;
    localparam int AF    = 2;
    localparam int OW    = $clog2(DEPTH) + 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cc_resp_scheduler_if #(.DEPTH(DEPTH)) bus ();

    cc_resp_scheduler #(.DEPTH(DEPTH), .BURST_LEN(BL), .AFULL_THRESHOLD(AF)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int total = 0;
    int bad   = 0;

    // Model: pending tags, and the burst in flight (if any).
    bit mq[$];
    bit m_act, m_hit, m_err;
    int m_beat;

    // Output vector layout: {err, full, afull, occ, sel, rvalid, rlast, mrdy, srdy}
    function automatic logic [OW+7:0] exp_outs();
        logic sel, rv, rl, mr, sr;
        int   occ;
        sel = 0; rv = 0; rl = 0; mr = 0; sr = 0;
        occ = mq.size();
        if (m_act) begin
            rl = (m_beat == BL - 1);
            if (m_hit) begin
                sel = 1; rv = bus.ser_rvalid_i; sr = bus.inct_rready_i;
            end else begin
                rv = bus.mem_rvalid_i; mr = bus.inct_rready_i;
            end
        end
        return {m_err, occ == DEPTH, occ >= AF, OW'(occ), sel, rv, rl, mr, sr};
    endfunction

    function automatic logic [OW+7:0] obs_outs();
        return {bus.err_o, bus.tag_full_o, bus.tag_afull_o, bus.occupancy_o,
                bus.inct_sel_o, bus.inct_rvalid_o, bus.inct_rlast_o,
                bus.mem_rready_o, bus.ser_rready_o};
    endfunction

    function automatic bit want_last();
        return m_act && (m_beat == BL - 1);
    endfunction

    // Advance one clock edge and apply the same edge to the model.
    task automatic tick();
        int pre;
        bit beat, srcl, fin;
        @(posedge clk);
        if (!rst_n) begin
            mq.delete();
            m_act = 0; m_hit = 0; m_beat = 0; m_err = 0;
        end else begin
            pre  = mq.size();
            beat = m_act && bus.inct_rready_i && (m_hit ? bus.ser_rvalid_i : bus.mem_rvalid_i);
            srcl = m_hit ? bus.ser_rlast_i : bus.mem_rlast_i;
            if (beat && (srcl != (m_beat == BL - 1))) m_err = 1;
            if (bus.tag_wren_i && pre == DEPTH) m_err = 1;
            fin = !m_act || (beat && m_beat == BL - 1);
            if (beat) m_beat++;
            if (fin) begin
                m_beat = 0;
                if (pre > 0) begin
                    m_hit = mq.pop_front();
                    m_act = 1;
                end else begin
                    m_act = 0;
                end
            end
            if (bus.tag_wren_i && pre < DEPTH) mq.push_back(bus.tag_hit_i);
        end
        #1;
    endtask

    task automatic drive_quiet();
        bus.tag_wren_i = 0; bus.tag_hit_i = 0;
        bus.mem_rvalid_i = 0; bus.mem_rlast_i = 0;
        bus.ser_rvalid_i = 0; bus.ser_rlast_i = 0;
        bus.inct_rready_i = 0;
    endtask

    task automatic do_reset();
        drive_quiet();
        rst_n = 0;
        tick(); tick();
        rst_n = 1;
    endtask

    task automatic test_reset();
        logic [OW+7:0] ob;
        do_reset();
        #3;
        ob = obs_outs();
        total++;
        if (ob !== '0) begin
            bad++; $display("FAIL reset_outputs act=%h exp=0", ob);
        end
        total++;
        if (ob !== exp_outs()) begin
            bad++; $display("FAIL reset_model act=%h exp=%h", ob, exp_outs());
        end
        tick();
    endtask

    task automatic test_single_miss();
        logic [OW+7:0] ob, ex;
        int mr_n = 0, rl_beat = 0, beats = 0, sel_n = 0;
        for (int c = 0; c < 14; c++) begin
            bus.tag_wren_i = (c == 0); bus.tag_hit_i = 0;
            bus.mem_rvalid_i = 1; bus.inct_rready_i = 1;
            bus.mem_rlast_i = want_last();
            #3;
            ob = obs_outs(); ex = exp_outs();
            total++;
            if (ob !== ex) begin
                bad++; $display("FAIL miss_cycle c=%0d act=%h exp=%h", c, ob, ex);
            end
            if (bus.mem_rready_o) mr_n++;
            if (bus.inct_sel_o) sel_n++;
            if (bus.inct_rvalid_o && bus.inct_rready_i) begin
                beats++;
                if (bus.inct_rlast_o) rl_beat = beats;
            end
            tick();
        end
        drive_quiet();
        total++;
        if (mr_n !== BL) begin bad++; $display("FAIL miss_rready_cycles act=%0d exp=%0d", mr_n, BL); end
        total++;
        if (rl_beat !== BL) begin bad++; $display("FAIL miss_rlast_beat act=%0d exp=%0d", rl_beat, BL); end
        total++;
        if (sel_n !== 0) begin bad++; $display("FAIL miss_sel act=%0d exp=0", sel_n); end
        #3;
        total++;
        if ({bus.err_o, bus.inct_rvalid_o, bus.occupancy_o} !== '0) begin
            bad++; $display("FAIL miss_idle_end err=%b rvalid=%b occ=%0d exp all 0",
                            bus.err_o, bus.inct_rvalid_o, bus.occupancy_o);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [OW+7:0] ob, ex;
        logic [2:0] sels = '0;
        int beats = 0, first = -1, last = -1, nb = 0, peak = 0, mpeak = 0;
        bit tags[3] = '{1, 0, 1};
        for (int c = 0; c < 34; c++) begin
            bus.tag_wren_i = (c < 3); bus.tag_hit_i = (c < 3) ? tags[c] : 1'b0;
            bus.mem_rvalid_i = 1; bus.ser_rvalid_i = 1; bus.inct_rready_i = 1;
            bus.mem_rlast_i = want_last(); bus.ser_rlast_i = want_last();
            #3;
            ob = obs_outs(); ex = exp_outs();
            total++;
            if (ob !== ex) begin
                bad++; $display("FAIL b2b_cycle c=%0d act=%h exp=%h", c, ob, ex);
            end
            if (int'(bus.occupancy_o) > peak) peak = int'(bus.occupancy_o);
            if (mq.size() > mpeak) mpeak = mq.size();
            if (bus.inct_rvalid_o && bus.inct_rready_i) begin
                if (first < 0) first = c;
                last = c;
                if (beats % BL == 0 && nb < 3) begin
                    sels[2-nb] = bus.inct_sel_o; nb++;
                end
                beats++;
            end
            tick();
        end
        drive_quiet();
        total++;
        if (beats !== 3 * BL) begin bad++; $display("FAIL b2b_beats act=%0d exp=%0d", beats, 3 * BL); end
        total++;
        if (last - first + 1 !== 3 * BL) begin
            bad++; $display("FAIL b2b_bubble span act=%0d exp=%0d", last - first + 1, 3 * BL);
        end
        total++;
        if (sels !== 3'b101) begin bad++; $display("FAIL b2b_sel_seq act=%b exp=101", sels); end
        total++;
        if (peak !== mpeak) begin bad++; $display("FAIL b2b_peak_occ act=%0d exp=%0d", peak, mpeak); end
        total++;
        if (bus.err_o !== 1'b0) begin bad++; $display("FAIL b2b_err act=%b exp=0", bus.err_o); end
    endtask

    task automatic test_backpressure();
        logic [OW+7:0] ob, ex;
        int beats = 0, mr_n = 0, mirror_bad = 0;
        for (int c = 0; c < 24; c++) begin
            bus.tag_wren_i = (c == 0); bus.tag_hit_i = 1;
            bus.ser_rvalid_i = 1; bus.mem_rvalid_i = 1;
            bus.mem_rlast_i = $urandom_range(1);
            bus.inct_rready_i = c[0];
            bus.ser_rlast_i = want_last();
            #3;
            ob = obs_outs(); ex = exp_outs();
            total++;
            if (ob !== ex) begin
                bad++; $display("FAIL bp_cycle c=%0d act=%h exp=%h", c, ob, ex);
            end
            if (bus.mem_rready_o) mr_n++;
            if (bus.inct_sel_o && bus.ser_rready_o !== bus.inct_rready_i) mirror_bad++;
            if (bus.inct_rvalid_o && bus.inct_rready_i) beats++;
            tick();
        end
        drive_quiet();
        total++;
        if (beats !== BL) begin bad++; $display("FAIL bp_beats act=%0d exp=%0d", beats, BL); end
        total++;
        if (mr_n !== 0) begin bad++; $display("FAIL bp_mem_rready act=%0d exp=0", mr_n); end
        total++;
        if (mirror_bad !== 0) begin bad++; $display("FAIL bp_ser_rready_mirror act=%0d exp=0", mirror_bad); end
    endtask

    task automatic test_full();
        logic [OW+7:0] ob, ex;
        int afull_occ = -1, full_occ = -1;
        drive_quiet();
        for (int c = 0; c < 8; c++) begin
            bus.tag_wren_i = (c < 6); bus.tag_hit_i = c[0];
            #3;
            ob = obs_outs(); ex = exp_outs();
            total++;
            if (ob !== ex) begin
                bad++; $display("FAIL full_cycle c=%0d act=%h exp=%h", c, ob, ex);
            end
            if (afull_occ < 0 && bus.tag_afull_o) afull_occ = int'(bus.occupancy_o);
            if (full_occ < 0 && bus.tag_full_o) full_occ = int'(bus.occupancy_o);
            tick();
        end
        drive_quiet();
        #3;
        total++;
        if (afull_occ !== AF) begin bad++; $display("FAIL full_afull_at act=%0d exp=%0d", afull_occ, AF); end
        total++;
        if (full_occ !== DEPTH) begin bad++; $display("FAIL full_full_at act=%0d exp=%0d", full_occ, DEPTH); end
        total++;
        if ({bus.err_o, bus.occupancy_o} !== {1'b1, OW'(DEPTH)}) begin
            bad++; $display("FAIL full_drop err=%b occ=%0d exp err=1 occ=%0d", bus.err_o, bus.occupancy_o, DEPTH);
        end
        tick();
        do_reset();
    endtask

    task automatic test_rlast_err();
        logic [OW+7:0] ob, ex;
        int beats = 0, rl_beat = 0, err_beat = 0;
        for (int c = 0; c < 14; c++) begin
            bus.tag_wren_i = (c == 0); bus.tag_hit_i = 0;
            bus.mem_rvalid_i = 1; bus.inct_rready_i = 1;
            bus.mem_rlast_i = m_act && !m_hit && (m_beat == 5);
            #3;
            ob = obs_outs(); ex = exp_outs();
            total++;
            if (ob !== ex) begin
                bad++; $display("FAIL rlerr_cycle c=%0d act=%h exp=%h", c, ob, ex);
            end
            if (bus.err_o && err_beat == 0) err_beat = beats;
            if (bus.inct_rvalid_o && bus.inct_rready_i) begin
                beats++;
                if (bus.inct_rlast_o) rl_beat = beats;
            end
            tick();
        end
        drive_quiet();
        total++;
        if (rl_beat !== BL) begin bad++; $display("FAIL rlerr_rlast_beat act=%0d exp=%0d", rl_beat, BL); end
        total++;
        if (err_beat !== 6) begin bad++; $display("FAIL rlerr_err_after_beat act=%0d exp=6", err_beat); end
        do_reset();
    endtask

    task automatic test_midreset();
        logic [OW+7:0] ob, ex;
        int c = 0, rv_n = 0;
        while (!(m_act && m_beat == 3) && c < 40) begin
            bus.tag_wren_i = (c < 3); bus.tag_hit_i = 1;
            bus.ser_rvalid_i = 1; bus.inct_rready_i = 1;
            bus.ser_rlast_i = want_last();
            #3;
            ob = obs_outs(); ex = exp_outs();
            total++;
            if (ob !== ex) begin
                bad++; $display("FAIL mrst_cycle c=%0d act=%h exp=%h", c, ob, ex);
            end
            tick();
            c++;
        end
        total++;
        if (c >= 40 || mq.size() != 2) begin
            bad++; $display("FAIL mrst_setup cycles=%0d queued=%0d exp <40 and 2", c, mq.size());
        end
        bus.tag_wren_i = 0;
        rst_n = 0;
        tick(); tick();
        rst_n = 1;
        for (int k = 0; k < 16; k++) begin
            bus.ser_rvalid_i = 1; bus.mem_rvalid_i = 1; bus.inct_rready_i = 1;
            #3;
            if (bus.inct_rvalid_o) rv_n++;
            if (k == 0) begin
                total++;
                if (obs_outs() !== '0) begin
                    bad++; $display("FAIL mrst_outs act=%h exp=0", obs_outs());
                end
            end
            tick();
        end
        total++;
        if (rv_n !== 0) begin bad++; $display("FAIL mrst_residual_beats act=%0d exp=0", rv_n); end
        drive_quiet();
    endtask

    task automatic test_random();
        logic [OW+7:0] ob, ex;
        int errs = 0;
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            rst_n = ($urandom_range(199) != 0);
            bus.tag_wren_i    = ($urandom_range(3) == 0);
            bus.tag_hit_i     = $urandom_range(1);
            bus.mem_rvalid_i  = $urandom_range(1);
            bus.ser_rvalid_i  = $urandom_range(1);
            bus.inct_rready_i = ($urandom_range(3) != 0);
            bus.mem_rlast_i   = want_last() ^ ($urandom_range(99) == 0);
            bus.ser_rlast_i   = want_last() ^ ($urandom_range(99) == 0);
            #3;
            ob = obs_outs(); ex = exp_outs();
            total++;
            if (ob !== ex) begin
                bad++; errs++;
                if (errs < 10) $display("FAIL rand_cycle c=%0d act=%h exp=%h", c, ob, ex);
            end
            tick();
        end
        rst_n = 1;
        drive_quiet();
    endtask

    initial begin
        drive_quiet();
        m_act = 0; m_hit = 0; m_beat = 0; m_err = 0;
        test_reset();
        test_single_miss();
        test_back_to_back();
        test_backpressure();
        test_full();
        test_rlast_err();
        test_midreset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
